// File: rtl/ext_mem_pkg.sv
// rtl/ext_mem_pkg.sv - shared types and constants for the external memory arbiter
package ext_mem_pkg;

    localparam int DEFAULT_LOG2_OF_MEM_HEIGHT = 20;
    localparam int DEFAULT_EXT_MEM_WIDTH      = 32;
    localparam int READ_LATENCY_TOTAL         = 2;

    typedef logic req_id_t;

    localparam req_id_t REQ_COMPUTE = 1'b0;
    localparam req_id_t REQ_HOST    = 1'b1;

    typedef logic [DEFAULT_LOG2_OF_MEM_HEIGHT-1:0] mem_addr_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/ext_mem_arbiter_if.sv
// rtl/ext_mem_arbiter_if.sv - two-requester request/response bus of the memory arbiter
interface ext_mem_arbiter_if
    import ext_mem_pkg::*;
#(
    parameter int LOG2_OF_MEM_HEIGHT = DEFAULT_LOG2_OF_MEM_HEIGHT,
    parameter int EXT_MEM_WIDTH      = DEFAULT_EXT_MEM_WIDTH
) ();
    logic [1:0]                    req_valid;
    logic [1:0]                    req_ready;
    logic [1:0]                    req_we;
    logic [LOG2_OF_MEM_HEIGHT-1:0] req_addr  [2];
    logic [EXT_MEM_WIDTH-1:0]      req_wdata [2];
    logic [1:0]                    rsp_valid;
    logic [EXT_MEM_WIDTH-1:0]      rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter; pointer passes to the loser on a contended, accepted grant
module rr_arbiter2
    import ext_mem_pkg::*;
(
    input  logic       clk,
    input  logic       arst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    req_id_t ptr_q;
    req_id_t ptr_d;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr_q <= REQ_COMPUTE;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && (&req)) begin
            ptr_d = ~ptr_q;
        end
    end

    always_comb begin
        grant = req;
        if (&req) begin
            grant = (ptr_q == REQ_HOST) ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/ext_mem_arbiter.sv
// rtl/ext_mem_arbiter.sv - shares one external memory between compute and host; read and write channels arbitrated independently
module ext_mem_arbiter
    import ext_mem_pkg::*;
#(
    parameter int LOG2_OF_MEM_HEIGHT = DEFAULT_LOG2_OF_MEM_HEIGHT,
    parameter int EXT_MEM_WIDTH      = DEFAULT_EXT_MEM_WIDTH
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    ext_mem_arbiter_if.slave              bus,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] ext_mem_read_addr,
    input  logic [EXT_MEM_WIDTH-1:0]      ext_mem_qout,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] ext_mem_write_addr,
    output logic [EXT_MEM_WIDTH-1:0]      ext_mem_din,
    output logic                          ext_mem_write_en
);
    logic [1:0] wr_req, rd_req, wr_gnt, rd_gnt;
    req_id_t    wr_id, rd_id;
    logic       hazard, rd_accept, wr_accept;

    logic [LOG2_OF_MEM_HEIGHT-1:0] read_addr_q, read_addr_d;
    logic [LOG2_OF_MEM_HEIGHT-1:0] write_addr_q, write_addr_d;
    logic [EXT_MEM_WIDTH-1:0]      din_q, din_d;
    logic                          write_en_q, write_en_d;
    rd_tag_t                       tag_q [READ_LATENCY_TOTAL];
    rd_tag_t                       tag_d [READ_LATENCY_TOTAL];

    assign wr_req = bus.req_valid & bus.req_we;
    assign rd_req = bus.req_valid & ~bus.req_we;

    rr_arbiter2 u_wr_arb (
        .clk     (clk),
        .arst_n  (arst_n_in),
        .req     (wr_req),
        .advance (1'b1),
        .grant   (wr_gnt)
    );

    rr_arbiter2 u_rd_arb (
        .clk     (clk),
        .arst_n  (arst_n_in),
        .req     (rd_req),
        .advance (rd_accept),
        .grant   (rd_gnt)
    );

    assign wr_id     = wr_gnt[REQ_HOST];
    assign rd_id     = rd_gnt[REQ_HOST];
    assign wr_accept = |wr_gnt;
    // A read racing a write to the same word would sample the memory on the same
    // edge as the write commits, so the read waits one cycle and sees the new data.
    assign hazard    = wr_accept && (|rd_gnt) && (bus.req_addr[wr_id] == bus.req_addr[rd_id]);
    assign rd_accept = (|rd_gnt) && !hazard;

    assign bus.req_ready = wr_gnt | (rd_gnt & {2{rd_accept}});

    always_comb begin
        write_en_d   = wr_accept;
        write_addr_d = write_addr_q;
        din_d        = din_q;
        read_addr_d  = read_addr_q;
        if (wr_accept) begin
            write_addr_d = bus.req_addr[wr_id];
            din_d        = bus.req_wdata[wr_id];
        end
        if (rd_accept) begin
            read_addr_d = bus.req_addr[rd_id];
        end
        tag_d[0] = '{valid: rd_accept, id: rd_id};
        for (int i = 1; i < READ_LATENCY_TOTAL; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            din_q        <= '0;
            read_addr_q  <= '0;
            for (int i = 0; i < READ_LATENCY_TOTAL; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            din_q        <= din_d;
            read_addr_q  <= read_addr_d;
            for (int i = 0; i < READ_LATENCY_TOTAL; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign ext_mem_write_en   = write_en_q;
    assign ext_mem_write_addr = write_addr_q;
    assign ext_mem_din        = din_q;
    assign ext_mem_read_addr  = read_addr_q;

    assign bus.rsp_valid = tag_q[READ_LATENCY_TOTAL-1].valid
                         ? {tag_q[READ_LATENCY_TOTAL-1].id, ~tag_q[READ_LATENCY_TOTAL-1].id}
                         : 2'b00;
    assign bus.rsp_data  = tag_q[READ_LATENCY_TOTAL-1].valid ? ext_mem_qout : '0;
endmodule
